// File: rtl/mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mult_pipe
// Purpose  : Three-stage pipelined WIDTH x WIDTH integer multiplier. It handles
//            MULT (signed) and MULTU (unsigned) and carries an opaque tag with
//            each operation. It has a valid/ready handshake on both sides, a
//            global stall under output backpressure, and a flush that kills
//            every operation in flight.
// Ports    : clk, rst_n (async, active-low)  - clock / reset
//            flush                           - kill all in-flight ops
//            in_valid/in_ready               - input handshake
//            in_signed, in_a, in_b, in_tag   - operation (mode, operands, tag)
//            out_valid/out_ready             - output handshake
//            out_hi, out_lo, out_tag         - {hi,lo} product and tag
// Revision : 1.0 - initial release
// ============================================================================
module mult_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic [TAG_W-1:0] out_tag
);

  localparam int H   = WIDTH / 2;         // split point of the multiplier
  localparam int PPW = WIDTH + H + 2;     // exact width of (W+1) x (H+1) signed product
  localparam int PW  = 2 * WIDTH;         // final product width

  // S1: sign-extended operands
  logic             v1_q, v1_d;
  logic [WIDTH:0]   a1_q, a1_d;
  logic [WIDTH:0]   b1_q, b1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // S2: partial products
  logic             v2_q, v2_d;
  logic [PPW-1:0]   pp_lo_q, pp_lo_d;
  logic [PPW-1:0]   pp_hi_q, pp_hi_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  // S3: final product, drives the outputs
  logic             v3_q, v3_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  logic             stall;

  // Operands sign-extended to the partial-product width so that a plain
  // same-width multiply yields the exact two's-complement product.
  logic [PPW-1:0]   a_ext;
  logic [PPW-1:0]   b_lo_ext;
  logic [PPW-1:0]   b_hi_ext;

  assign a_ext    = {{(PPW-WIDTH-1){a1_q[WIDTH]}}, a1_q};
  // Low half of b is an unsigned H-bit field.
  assign b_lo_ext = {{(PPW-H){1'b0}}, b1_q[H-1:0]};
  // Upper part of b_x (H+1 bits) carries the sign of the extended operand.
  assign b_hi_ext = {{(PPW-H-1){b1_q[WIDTH]}}, b1_q[WIDTH:H]};

  // The whole pipe freezes only when the result in S3 is not taken.
  assign stall = v3_q & ~out_ready;

  always_comb begin
    v1_d    = v1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    tag1_d  = tag1_q;
    v2_d    = v2_q;
    pp_lo_d = pp_lo_q;
    pp_hi_d = pp_hi_q;
    tag2_d  = tag2_q;
    v3_d    = v3_q;
    prod_d  = prod_q;
    tag3_d  = tag3_q;

    if (!stall) begin
      // Data registers load regardless of valid; only the valid bits matter.
      v1_d    = in_valid;
      a1_d    = {in_signed & in_a[WIDTH-1], in_a};
      b1_d    = {in_signed & in_b[WIDTH-1], in_b};
      tag1_d  = in_tag;

      v2_d    = v1_q;
      pp_lo_d = a_ext * b_lo_ext;
      pp_hi_d = a_ext * b_hi_ext;
      tag2_d  = tag1_q;

      v3_d    = v2_q;
      // Recombine modulo 2^PW; the truncated sum equals the exact product.
      prod_d  = PW'($signed(pp_lo_q)) + PW'({pp_hi_q, {H{1'b0}}});
      tag3_d  = tag2_q;
    end

    // Flush wins over stall and also drops this cycle's input.
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      pp_lo_q <= '0;
      pp_hi_q <= '0;
      tag2_q  <= '0;
      v3_q    <= 1'b0;
      prod_q  <= '0;
      tag3_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      pp_lo_q <= pp_lo_d;
      pp_hi_q <= pp_hi_d;
      tag2_q  <= tag2_d;
      v3_q    <= v3_d;
      prod_q  <= prod_d;
      tag3_q  <= tag3_d;
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign out_hi    = prod_q[PW-1:WIDTH];
  assign out_lo    = prod_q[WIDTH-1:0];
  assign out_tag   = tag3_q;

endmodule
`default_nettype wire
